// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control unit.
// Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB, decodes the
// datapath strobes and selects from the current state and the IR fields, and
// counts retired (defined) instructions.
module mc_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  output logic        pcwr,
  output logic        irwr,
  output logic        regwr,
  output logic        memwr,
  output logic [1:0]  npc_sel,
  output logic [1:0]  regdst,
  output logic [1:0]  memtoreg,
  output logic        alusrc,
  output logic        extop,
  output logic [1:0]  aluop,
  output logic [2:0]  state,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] retired_q, retired_d;
  logic        retire_s;

  // Instruction decode from the IR fields
  logic is_rtype_s, is_addu_s, is_subu_s, is_jr_s;
  logic is_ori_s, is_lw_s, is_sw_s, is_beq_s, is_lui_s, is_j_s, is_jal_s;
  logic is_def_s;

  assign is_rtype_s = (opcode == 6'b000000);
  assign is_addu_s  = is_rtype_s && (funct == 6'b100001);
  assign is_subu_s  = is_rtype_s && (funct == 6'b100011);
  assign is_jr_s    = is_rtype_s && (funct == 6'b001000);
  assign is_ori_s   = (opcode == 6'b001101);
  assign is_lw_s    = (opcode == 6'b100011);
  assign is_sw_s    = (opcode == 6'b101011);
  assign is_beq_s   = (opcode == 6'b000100);
  assign is_lui_s   = (opcode == 6'b001111);
  assign is_j_s     = (opcode == 6'b000010);
  assign is_jal_s   = (opcode == 6'b000011);
  assign is_def_s   = is_addu_s | is_subu_s | is_jr_s | is_ori_s | is_lw_s |
                      is_sw_s | is_beq_s | is_lui_s | is_j_s | is_jal_s;

  // Next-state and output decode; reset forces every control output low
  always_comb begin
    state_d  = S_FETCH;
    retire_s = 1'b0;
    pcwr     = 1'b0;
    irwr     = 1'b0;
    regwr    = 1'b0;
    memwr    = 1'b0;
    npc_sel  = 2'b00;
    regdst   = 2'b00;
    memtoreg = 2'b00;
    alusrc   = 1'b0;
    extop    = 1'b0;
    aluop    = 2'b00;
    if (reset) begin
      state_d = S_FETCH;
    end else begin
      case (state_q)
        S_FETCH: begin
          irwr    = 1'b1;
          pcwr    = 1'b1;
          npc_sel = 2'b00;
          state_d = S_DECODE;
        end
        S_DECODE: begin
          if (is_j_s || is_jal_s) begin
            pcwr     = 1'b1;
            npc_sel  = 2'b10;
            regwr    = is_jal_s;
            regdst   = is_jal_s ? 2'b10 : 2'b00;
            memtoreg = is_jal_s ? 2'b10 : 2'b00;
            retire_s = 1'b1;
            state_d  = S_FETCH;
          end else if (is_jr_s) begin
            pcwr     = 1'b1;
            npc_sel  = 2'b11;
            retire_s = 1'b1;
            state_d  = S_FETCH;
          end else if (is_def_s) begin
            state_d = S_EXEC;
          end else begin
            state_d = S_FETCH;
          end
        end
        S_EXEC: begin
          if (is_beq_s) begin
            aluop    = 2'b01;
            npc_sel  = 2'b01;
            pcwr     = zero;
            extop    = 1'b1;
            retire_s = 1'b1;
            state_d  = S_FETCH;
          end else if (is_lw_s || is_sw_s) begin
            alusrc  = 1'b1;
            extop   = 1'b1;
            state_d = S_MEM;
          end else if (is_addu_s) begin
            state_d = S_WB;
          end else if (is_subu_s) begin
            aluop   = 2'b01;
            state_d = S_WB;
          end else if (is_ori_s) begin
            aluop   = 2'b10;
            alusrc  = 1'b1;
            state_d = S_WB;
          end else if (is_lui_s) begin
            aluop   = 2'b11;
            alusrc  = 1'b1;
            state_d = S_WB;
          end else begin
            state_d = S_FETCH;
          end
        end
        S_MEM: begin
          // Address computation stays on the ALU through the memory access
          alusrc = 1'b1;
          extop  = 1'b1;
          if (is_sw_s) begin
            memwr    = 1'b1;
            retire_s = 1'b1;
            state_d  = S_FETCH;
          end else if (is_lw_s) begin
            state_d = S_WB;
          end else begin
            state_d = S_FETCH;
          end
        end
        S_WB: begin
          regwr = 1'b1;
          if (is_lw_s) begin
            memtoreg = 2'b01;
          end else if (is_addu_s || is_subu_s) begin
            regdst = 2'b01;
          end else begin
            regdst = 2'b00;
          end
          retire_s = is_def_s;
          state_d  = S_FETCH;
        end
        default: begin
          state_d = S_FETCH;
        end
      endcase
    end
  end

  // Retirement counter next value; wraps naturally at 32 bits
  always_comb begin
    retired_d = retired_q;
    if (retire_s) begin
      retired_d = retired_q + 32'd1;
    end else begin
      retired_d = retired_q;
    end
  end

  // State and retirement registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      retired_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed self-checking bench for mc_ctrl.
module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        pcwr, irwr, regwr, memwr;
  logic [1:0]  npc_sel, regdst, memtoreg, aluop;
  logic        alusrc, extop;
  logic [2:0]  state;
  logic [31:0] retired;

  int total = 0;
  int bad   = 0;

  // Packed view: {pcwr,irwr,regwr,memwr,npc_sel,regdst,memtoreg,alusrc,extop,aluop}
  logic [13:0] ctrl;
  assign ctrl = {pcwr, irwr, regwr, memwr, npc_sel, regdst, memtoreg, alusrc, extop, aluop};

  localparam logic [13:0] C_NONE    = 14'b0000_00_00_00_0_0_00;
  localparam logic [13:0] C_FETCH   = 14'b1100_00_00_00_0_0_00;
  localparam logic [13:0] C_RWB     = 14'b0010_00_01_00_0_0_00;
  localparam logic [13:0] C_SUBU_EX = 14'b0000_00_00_00_0_0_01;
  localparam logic [13:0] C_MEM_EX  = 14'b0000_00_00_00_1_1_00;
  localparam logic [13:0] C_SW_MEM  = 14'b0001_00_00_00_1_1_00;
  localparam logic [13:0] C_LW_WB   = 14'b0010_00_00_01_0_0_00;
  localparam logic [13:0] C_IWB     = 14'b0010_00_00_00_0_0_00;
  localparam logic [13:0] C_ORI_EX  = 14'b0000_00_00_00_1_0_10;
  localparam logic [13:0] C_LUI_EX  = 14'b0000_00_00_00_1_0_11;
  localparam logic [13:0] C_BEQ_T   = 14'b1000_01_00_00_0_1_01;
  localparam logic [13:0] C_BEQ_N   = 14'b0000_01_00_00_0_1_01;
  localparam logic [13:0] C_JAL_D   = 14'b1010_10_10_10_0_0_00;
  localparam logic [13:0] C_JR_D    = 14'b1000_11_00_00_0_0_00;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_LUI = 6'b001111;
  localparam logic [5:0] OP_JAL = 6'b000011;
  localparam logic [5:0] OP_BAD = 6'b111111;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_JR   = 6'b001000;

  mc_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .opcode   (opcode),
    .funct    (funct),
    .zero     (zero),
    .pcwr     (pcwr),
    .irwr     (irwr),
    .regwr    (regwr),
    .memwr    (memwr),
    .npc_sel  (npc_sel),
    .regdst   (regdst),
    .memtoreg (memtoreg),
    .alusrc   (alusrc),
    .extop    (extop),
    .aluop    (aluop),
    .state    (state),
    .retired  (retired)
  );

  // 10 time-unit clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check state and controls of the current cycle, then advance one cycle
  task automatic cyc(input string tag, input logic [2:0] exp_state, input logic [13:0] exp_ctrl);
    chk({tag, ".state"}, {29'd0, state}, {29'd0, exp_state});
    chk({tag, ".ctrl"},  {18'd0, ctrl},  {18'd0, exp_ctrl});
    @(negedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [5:0] op, input logic [5:0] fn);
    opcode = op;
    funct  = fn;
  endtask

  initial begin
    reset  = 1'b1;
    opcode = 6'b000000;
    funct  = 6'b000000;
    zero   = 1'b0;
    @(negedge clk);
    #1;
    // Reset held for three edges: state FETCH, everything else zero
    for (int i = 0; i < 3; i++) begin
      chk("rst.retired", retired, 32'd0);
      cyc("rst", 3'd0, C_NONE);
    end
    reset = 1'b0;
    #1;

    // addu: 0,1,2,4
    set_instr(OP_R, FN_ADDU);
    cyc("addu.F", 3'd0, C_FETCH);
    cyc("addu.D", 3'd1, C_NONE);
    cyc("addu.E", 3'd2, C_NONE);
    cyc("addu.W", 3'd4, C_RWB);
    chk("addu.retired", retired, 32'd1);

    // lw: 0,1,2,3,4
    set_instr(OP_LW, 6'b000000);
    cyc("lw.F", 3'd0, C_FETCH);
    cyc("lw.D", 3'd1, C_NONE);
    cyc("lw.E", 3'd2, C_MEM_EX);
    cyc("lw.M", 3'd3, C_MEM_EX);
    cyc("lw.W", 3'd4, C_LW_WB);
    chk("lw.retired", retired, 32'd2);

    // sw: 0,1,2,3
    set_instr(OP_SW, 6'b000000);
    cyc("sw.F", 3'd0, C_FETCH);
    cyc("sw.D", 3'd1, C_NONE);
    cyc("sw.E", 3'd2, C_MEM_EX);
    cyc("sw.M", 3'd3, C_SW_MEM);
    chk("sw.retired", retired, 32'd3);

    // subu
    set_instr(OP_R, FN_SUBU);
    cyc("subu.F", 3'd0, C_FETCH);
    cyc("subu.D", 3'd1, C_NONE);
    cyc("subu.E", 3'd2, C_SUBU_EX);
    cyc("subu.W", 3'd4, C_RWB);
    chk("subu.retired", retired, 32'd4);

    // lui
    set_instr(OP_LUI, 6'b000000);
    cyc("lui.F", 3'd0, C_FETCH);
    cyc("lui.D", 3'd1, C_NONE);
    cyc("lui.E", 3'd2, C_LUI_EX);
    cyc("lui.W", 3'd4, C_IWB);
    chk("lui.retired", retired, 32'd5);

    // beq taken
    set_instr(OP_BEQ, 6'b000000);
    zero = 1'b1;
    cyc("beqt.F", 3'd0, C_FETCH);
    cyc("beqt.D", 3'd1, C_NONE);
    cyc("beqt.E", 3'd2, C_BEQ_T);
    chk("beqt.retired", retired, 32'd6);

    // beq not taken; pcwr follows zero combinationally inside EXEC
    zero = 1'b0;
    cyc("beqn.F", 3'd0, C_FETCH);
    cyc("beqn.D", 3'd1, C_NONE);
    chk("beqn.E.ctrl0", {18'd0, ctrl}, {18'd0, C_BEQ_N});
    zero = 1'b1;
    #1;
    chk("beqn.E.ctrl1", {18'd0, ctrl}, {18'd0, C_BEQ_T});
    zero = 1'b0;
    #1;
    cyc("beqn.E", 3'd2, C_BEQ_N);
    chk("beqn.retired", retired, 32'd7);

    // jal, jr: two cycles each
    set_instr(OP_JAL, 6'b000000);
    cyc("jal.F", 3'd0, C_FETCH);
    cyc("jal.D", 3'd1, C_JAL_D);
    chk("jal.retired", retired, 32'd8);
    set_instr(OP_R, FN_JR);
    cyc("jr.F", 3'd0, C_FETCH);
    cyc("jr.D", 3'd1, C_JR_D);
    chk("jr.retired", retired, 32'd9);

    // Undefined opcode: DECODE without strobes, not counted
    set_instr(OP_BAD, 6'b000000);
    cyc("bad.F", 3'd0, C_FETCH);
    cyc("bad.D", 3'd1, C_NONE);
    chk("bad.state", {29'd0, state}, 32'd0);
    chk("bad.retired", retired, 32'd9);

    // Reset pulsed during lw MEM
    set_instr(OP_LW, 6'b000000);
    cyc("lwr.F", 3'd0, C_FETCH);
    cyc("lwr.D", 3'd1, C_NONE);
    cyc("lwr.E", 3'd2, C_MEM_EX);
    chk("lwr.M.state", {29'd0, state}, 32'd3);
    reset = 1'b1;
    #1;
    cyc("lwr.M.rst", 3'd3, C_NONE);
    chk("lwr.after.retired", retired, 32'd0);
    cyc("lwr.after", 3'd0, C_NONE);
    reset = 1'b0;
    #1;

    // Counter wrap: preload all-ones, then retire ori
    set_instr(OP_ORI, 6'b000000);
    chk("ori.F.state", {29'd0, state}, 32'd0);
    chk("ori.F.ctrl", {18'd0, ctrl}, {18'd0, C_FETCH});
    force dut.retired_q = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    release dut.retired_q;
    @(negedge clk);
    #1;
    chk("ori.preload", retired, 32'hFFFF_FFFF);
    cyc("ori.D", 3'd1, C_NONE);
    cyc("ori.E", 3'd2, C_ORI_EX);
    cyc("ori.W", 3'd4, C_IWB);
    chk("ori.wrap", retired, 32'd0);
    chk("ori.next.state", {29'd0, state}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
